// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 size codes,
// FSM state encoding, bus-error fill word and access-width decoding.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [31:0] DMEM_BUSERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } dmem_width_e;

  // Undefined size codes (011, 11x) fall through to a full word access.
  function automatic dmem_width_e size_width(input logic [2:0] size);
    dmem_width_e w;
    case (size)
      SZ_B, SZ_BU: w = W_BYTE;
      SZ_H, SZ_HU: w = W_HALF;
      SZ_W:        w = W_WORD;
      default:     w = W_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core-side and memory-side signals of the data-memory controller.
// master = the controller, slave = the core/memory environment around it.
interface dmem_ctrl_if;
  import dmem_pkg::*;

  // Memory handshake: mem_req rises from a register and stays high, with
  // mem_we/addr/be/wdata stable, until the rising edge at which mem_ack is
  // sampled high; mem_rdata is valid with that ack. The memory keeps mem_ack
  // low whenever mem_req is low, and any ack seen outside WAIT is ignored.
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_size;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_misalign;
  logic        cpu_buserr;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, cpu_misalign, cpu_buserr,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, cpu_misalign, cpu_buserr,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and replication, load byte/half
// selection with sign/zero extension, and the misalignment check.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  dmem_width_e width;
  logic        sext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    width    = size_width(size);
    // funct3[2] clear means a signed load (lb/lh).
    sext     = ~size[2];
    sel_byte = rdata[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misalign   = 1'b0;

    case (width)
      W_BYTE: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sext & sel_byte[7]}}, sel_byte};
        misalign   = 1'b0;
      end
      W_HALF: begin
        be         = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sext & sel_half[15]}}, sel_half};
        misalign   = offset[0];
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misalign   = |offset;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns core byte/half/word loads and stores into
// word-aligned req/ack accesses. Macro DMEM_TIMEOUT_EN adds a WAIT timeout.
module dmem_ctrl
  import dmem_pkg::*;
`ifdef DMEM_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYC = 64
  )
`endif
  (
    input  logic        clk,
    input  logic        reset,
    dmem_ctrl_if.master bus,
    output dmem_state_e dbg_state
  );

  dmem_state_e state;
  dmem_state_e next_state;

  logic [2:0]  lat_size;
  logic [1:0]  lat_off;
  logic [31:0] rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic [2:0]  size_sel;
  logic [1:0]  off_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;

  logic        accept;
  logic        ack_hit;
  logic        timeout;
  logic        stall;
  logic        misalign;

  // IDLE formats the incoming request; WAIT extracts load data at the
  // latched offset, so one lane unit serves both phases.
  assign size_sel = (state == ST_IDLE) ? bus.cpu_size      : lat_size;
  assign off_sel  = (state == ST_IDLE) ? bus.cpu_addr[1:0] : lat_off;

  dmem_align u_align (
    .size       (size_sel),
    .offset     (off_sel),
    .wdata      (bus.cpu_wdata),
    .rdata      (bus.mem_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misalign   (al_mis)
  );

  assign accept  = (state == ST_IDLE) && bus.cpu_req && !al_mis;
  assign ack_hit = (state == ST_WAIT) && bus.mem_ack;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             buserr_q;

  // Fires on the last permitted WAIT cycle; an ack in that same cycle wins.
  assign timeout = (state == ST_WAIT) && !bus.mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buserr_q <= 1'b0;
    end else begin
      buserr_q <= timeout;
    end
  end

  assign bus.cpu_buserr = buserr_q;
`else
  assign timeout        = 1'b0;
  assign bus.cpu_buserr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_WAIT;
      ST_WAIT: if (ack_hit || timeout) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    case (state)
      ST_IDLE: begin
        misalign = bus.cpu_req && al_mis;
        stall    = bus.cpu_req && !al_mis;
      end
      ST_WAIT: stall = bus.cpu_req;
      default: begin
        stall    = 1'b0;
        misalign = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      lat_size    <= '0;
      lat_off     <= '0;
      rdata_q     <= '0;
    end else if (accept) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= bus.cpu_we;
      mem_addr_q  <= {bus.cpu_addr[31:2], 2'b00};
      mem_be_q    <= bus.cpu_we ? al_be : 4'b1111;
      mem_wdata_q <= al_wdata;
      lat_size    <= bus.cpu_size;
      lat_off     <= bus.cpu_addr[1:0];
    end else if (ack_hit) begin
      mem_req_q <= 1'b0;
      rdata_q   <= mem_we_q ? 32'h0 : al_rdata;
    end else if (timeout) begin
      mem_req_q <= 1'b0;
      rdata_q   <= DMEM_BUSERR_DATA;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.cpu_stall    = stall;
  assign bus.cpu_misalign = misalign;
  assign dbg_state        = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, random accesses against an
// arithmetic reference model, plus reset, stray-ack and timeout sequences.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  dmem_state_e dbg_state;
  dmem_ctrl_if bus();

`ifdef DMEM_TIMEOUT_EN
  localparam int TO_CYC = 4;
  dmem_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state));
`else
  localparam int TO_CYC = 0;
  dmem_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] rword;
    int          lat;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        misalign;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        buserr;
    int          wait_cyc;
  } exp_t;

  typedef struct packed {
    logic        misalign;
    int          stall_cyc;
    int          wait_cyc;
    logic        req_seen;
    logic        left_idle;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        unstable;
    logic        req_gap;
    logic [1:0]  done_state;
    logic        done_stall;
    logic        done_req;
    logic [31:0] rdata;
    logic        buserr;
    logic [1:0]  after_state;
  } obs_t;

  localparam int NV = 17;
  vec_t        tv[NV];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [2:0] size,
                              logic [31:0] rword, int lat, logic mis, logic [31:0] ea,
                              logic [3:0] ebe, logic [31:0] ew, logic [31:0] er);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.rword = rword; v.lat = lat;
    v.exp_mis = mis; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ew; v.exp_rdata = er;
    return v;
  endfunction

  // Reference model: access width from the size code, then plain arithmetic.
  function automatic exp_t model(logic we, logic [31:0] addr, logic [31:0] wdata,
                                 logic [2:0] size, logic [31:0] rword, int lat);
    exp_t   e;
    int     nb;
    int     off;
    longint v;
    longint m;
    e = '0;
    case (int'(size))
      0, 4:    nb = 1;
      1, 5:    nb = 2;
      default: nb = 4;
    endcase
    off        = int'(addr[1:0]);
    e.misalign = (off % nb) != 0;
    e.addr     = addr - 32'(off);
    e.be       = we ? 4'(((1 << nb) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
    m = (longint'(1) << (8 * nb)) - 1;
    v = (longint'(rword) >> (8 * off)) & m;
    if (nb < 4 && size[2] == 1'b0 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    e.rdata = we ? 32'h0 : 32'(v);
    if (TO_CYC > 0 && lat >= TO_CYC) begin
      e.wait_cyc = TO_CYC;
      e.rdata    = 32'hDEADBEEF;
      e.buserr   = 1'b1;
    end else begin
      e.wait_cyc = lat + 1;
    end
    return e;
  endfunction

  // Drives one core access and plays the memory, acking lat cycles into WAIT.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, input logic [31:0] rword, input int lat,
                            input logic mis, output obs_t o);
    int n;
    o = '0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_size = size; bus.mem_rdata = rword; bus.mem_ack = 1'b0;
    #1;
    o.misalign  = bus.cpu_misalign;
    o.stall_cyc = int'(bus.cpu_stall);
    if (mis) begin
      repeat (2) begin
        @(negedge clk); #1;
        if (bus.mem_req) o.req_seen = 1'b1;
        if (dbg_state != ST_IDLE) o.left_idle = 1'b1;
        if (bus.cpu_stall) o.stall_cyc++;
      end
      o.rdata = bus.cpu_rdata;
      bus.cpu_req = 1'b0;
      return;
    end
    @(negedge clk);
    n = 0;
    while (dbg_state == ST_WAIT && n < 200) begin
      bus.mem_ack = (n == lat);
      #1;
      if (bus.cpu_stall) o.stall_cyc++;
      if (!bus.mem_req) o.req_gap = 1'b1;
      if (n == 0) begin
        o.addr = bus.mem_addr; o.be = bus.mem_be; o.wdata = bus.mem_wdata; o.we = bus.mem_we;
      end else if ({o.addr, o.be, o.wdata, o.we} !==
                   {bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we}) begin
        o.unstable = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    o.wait_cyc  = n;
    bus.mem_ack = 1'b0;
    #1;
    o.done_state = dbg_state;
    o.done_stall = bus.cpu_stall;
    o.done_req   = bus.mem_req;
    o.rdata      = bus.cpu_rdata;
    o.buserr     = bus.cpu_buserr;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    o.after_state = dbg_state;
  endtask

  task automatic apply(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size,
                       input logic [31:0] rword, input int lat, input exp_t e);
    obs_t        o;
    logic [31:0] exp_rd;
    if (!e.misalign) exp_q.push_back(e.rdata);
    run_access(we, addr, wdata, size, rword, lat, e.misalign, o);
    chk({name, " misalign"}, 32'(o.misalign), 32'(e.misalign));
    if (e.misalign) begin
      chk({name, " mis_stall"}, 32'(o.stall_cyc), 32'd0);
      chk({name, " mis_no_req"}, 32'(o.req_seen), 32'd0);
      chk({name, " mis_idle"}, 32'(o.left_idle), 32'd0);
      chk({name, " mis_rdata_hold"}, o.rdata, last_rd);
    end else begin
      exp_rd = exp_q.pop_front();
      chk({name, " mem_addr"}, o.addr, e.addr);
      chk({name, " mem_be"}, 32'(o.be), 32'(e.be));
      chk({name, " mem_we"}, 32'(o.we), 32'(we));
      if (we) chk({name, " mem_wdata"}, o.wdata, e.wdata);
      chk({name, " mem_stable"}, 32'(o.unstable), 32'd0);
      chk({name, " req_held"}, 32'(o.req_gap), 32'd0);
      chk({name, " wait_cycles"}, 32'(o.wait_cyc), 32'(e.wait_cyc));
      chk({name, " stall_cycles"}, 32'(o.stall_cyc), 32'(e.wait_cyc + 1));
      chk({name, " done_state"}, 32'(o.done_state), 32'(ST_DONE));
      chk({name, " done_stall"}, 32'(o.done_stall), 32'd0);
      chk({name, " done_req"}, 32'(o.done_req), 32'd0);
      chk({name, " cpu_rdata"}, o.rdata, exp_rd);
      chk({name, " cpu_buserr"}, 32'(o.buserr), 32'(e.buserr));
      chk({name, " back_idle"}, 32'(o.after_state), 32'(ST_IDLE));
      last_rd = exp_rd;
    end
  endtask

  task automatic check_reset_values(input string name);
    chk({name, " state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({name, " mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({name, " mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({name, " mem_addr"}, bus.mem_addr, 32'd0);
    chk({name, " mem_be"}, 32'(bus.mem_be), 32'd0);
    chk({name, " mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({name, " cpu_rdata"}, bus.cpu_rdata, 32'd0);
    chk({name, " cpu_buserr"}, 32'(bus.cpu_buserr), 32'd0);
    chk({name, " cpu_stall"}, 32'(bus.cpu_stall), 32'd0);
    chk({name, " cpu_misalign"}, 32'(bus.cpu_misalign), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic we;
    logic [2:0] size;
    logic [31:0] addr, wdata, rword;
    int lat;

    tv[0]  = mk(0, 32'h100, 32'h0, SZ_W,  32'h89ABCDEF, 0, 0, 32'h100, 4'hF, 32'h0, 32'h89ABCDEF);
    tv[1]  = mk(0, 32'h103, 32'h0, SZ_B,  32'h80FFFF7F, 1, 0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80);
    tv[2]  = mk(0, 32'h103, 32'h0, SZ_BU, 32'h80FFFF7F, 0, 0, 32'h100, 4'hF, 32'h0, 32'h00000080);
    tv[3]  = mk(0, 32'h102, 32'h0, SZ_HU, 32'h80FFFF7F, 2, 0, 32'h100, 4'hF, 32'h0, 32'h000080FF);
    tv[4]  = mk(0, 32'h102, 32'h0, SZ_H,  32'h80FFFF7F, 0, 0, 32'h100, 4'hF, 32'h0, 32'hFFFF80FF);
    tv[5]  = mk(0, 32'h100, 32'h0, SZ_H,  32'h80FFFF7F, 3, 0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF7F);
    tv[6]  = mk(0, 32'h101, 32'h0, SZ_B,  32'h80FFFF7F, 1, 0, 32'h100, 4'hF, 32'h0, 32'hFFFFFFFF);
    tv[7]  = mk(1, 32'h101, 32'h12345678, SZ_B, 32'h0, 0, 0, 32'h100, 4'b0010, 32'h78787878, 32'h0);
    tv[8]  = mk(1, 32'h102, 32'h12345678, SZ_H, 32'h0, 2, 0, 32'h100, 4'b1100, 32'h56785678, 32'h0);
    tv[9]  = mk(1, 32'h204, 32'hCAFEF00D, SZ_W, 32'h0, 1, 0, 32'h204, 4'hF, 32'hCAFEF00D, 32'h0);
    tv[10] = mk(1, 32'h207, 32'h000000A5, SZ_B, 32'h0, 0, 0, 32'h204, 4'b1000, 32'hA5A5A5A5, 32'h0);
    tv[11] = mk(0, 32'h108, 32'h0, 3'b011, 32'h01234567, 0, 0, 32'h108, 4'hF, 32'h0, 32'h01234567);
    tv[12] = mk(0, 32'h102, 32'h0, SZ_W,  32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    tv[13] = mk(1, 32'h101, 32'h0, SZ_H,  32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    tv[14] = mk(0, 32'h10A, 32'h0, 3'b110, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    tv[15] = mk(0, 32'h103, 32'h0, SZ_HU, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
    tv[16] = mk(1, 32'h10C, 32'h11223344, 3'b111, 32'h0, 2, 0, 32'h10C, 4'hF, 32'h11223344, 32'h0);

    // Clock/reset
    reset = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_size = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      e = '0;
      e.misalign = tv[i].exp_mis; e.addr = tv[i].exp_addr; e.be = tv[i].exp_be;
      e.wdata = tv[i].exp_wdata; e.rdata = tv[i].exp_rdata; e.wait_cyc = tv[i].lat + 1;
      apply($sformatf("vec%0d", i), tv[i].we, tv[i].addr, tv[i].wdata, tv[i].size,
            tv[i].rword, tv[i].lat, e);
    end

    // Stray ack in IDLE must not start or complete anything
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    #1;
    chk("stray_ack state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk); #1;
    chk("stray_ack state2", 32'(dbg_state), 32'(ST_IDLE));
    chk("stray_ack mem_req", 32'(bus.mem_req), 32'd0);
    chk("stray_ack rdata_hold", bus.cpu_rdata, last_rd);
    bus.mem_ack = 1'b0;

    // Reset pulsed in the 3rd WAIT cycle of a slow access
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h300; bus.cpu_size = SZ_W;
    bus.mem_rdata = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid state_before", 32'(dbg_state), 32'(ST_WAIT));
    chk("rst_mid req_before", 32'(bus.mem_req), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid req_drop", 32'(bus.mem_req), 32'd0);
    bus.cpu_req = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    last_rd = '0;

`ifdef DMEM_TIMEOUT_EN
    e = '0; e.addr = 32'h400; e.be = 4'hF; e.rdata = 32'hDEADBEEF; e.buserr = 1'b1; e.wait_cyc = 4;
    apply("timeout", 1'b0, 32'h400, 32'h0, SZ_W, 32'h12345678, 1000, e);
    e.rdata = 32'h12345678; e.buserr = 1'b0;
    apply("ack_at_limit", 1'b0, 32'h400, 32'h0, SZ_W, 32'h12345678, 3, e);
`endif

    // Random accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      we    = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = $urandom;
      rword = $urandom;
      lat   = $urandom_range(0, 6);
      e     = model(we, addr, wdata, size, rword, lat);
      apply($sformatf("rand%0d", i), we, addr, wdata, size, rword, lat, e);
    end

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the single-cycle RV32I core's memory port, between the core and a word-wide, variable-latency data memory. It converts the core's byte/halfword/word load-store requests into word-aligned memory transactions with byte enables and a req/ack handshake. It stalls the core until the access completes, and sign- or zero-extends load data. Misaligned accesses are detected and never reach memory.

## Interface
- `TIMEOUT_CYC`, default 64: maximum cycles in WAIT before the access is aborted (only with `DMEM_TIMEOUT_EN`).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  core presents a load or store this cycle.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address (core ALU output).
- `cpu_wdata`  in  32  store data (rs2).
- `cpu_size`  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `cpu_rdata`  out  32  extended load data, valid in the DONE cycle.
- `cpu_stall`  out  1  hold PC and suppress RF write.
- `cpu_misalign`  out  1  misaligned-access flag, combinational.
- `cpu_buserr`  out  1  timeout flag, valid in the DONE cycle.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  word address, bits [1:0] always 00.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completion, sampled at the rising edge while `mem_req`=1.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **Misalign check:**
  - h/hu with `addr[0]`=1 is misaligned.
  - w with `addr[1:0]`≠0 is misaligned.
- **IDLE:**
  - On `cpu_req` and an aligned address: latch we, `addr[31:2]`, `addr[1:0]`, size, and lane-formatted wdata/be; go to WAIT.
  - `cpu_stall`=1 combinationally in this cycle.
  - On `cpu_req` and a misaligned address: `cpu_misalign`=1, `cpu_stall`=0, stay in IDLE, no memory access.
- **WAIT:**
  - `mem_req`=1 and `cpu_stall`=1.
  - On `mem_ack`: capture the extended load data (stores capture 0) and go to DONE.
- **DONE:**
  - `mem_req`=0 and `cpu_stall`=0, so the core retires the instruction with `cpu_rdata`.
  - `cpu_req` is ignored in this cycle (it is the completing access).
  - Always returns to IDLE.
- **Store formatting:**
  - sb: wdata = 4 copies of `wdata[7:0]`, be = 0001 << `addr[1:0]`.
  - sh: wdata = 2 copies of `wdata[15:0]`, be = 0011 << `addr[1:0]`.
  - sw: wdata unchanged, be = 1111.
- **Loads:**
  - be = 1111.
  - Select the byte/half at the latched offset.
  - b/h sign-extend; bu/hu zero-extend.
- **Undefined size codes** (011, 11x): treated as w.
- `cpu_rdata` holds its value until the next capture.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_wdata`, `mem_addr` = 0; `cpu_rdata` = 0; `cpu_buserr` = 0.
- `cpu_stall` and `cpu_misalign` are combinational and 0 when `cpu_req`=0.
- Minimum access is 3 cycles (IDLE, WAIT, DONE), with 2 stall cycles. Each additional cycle without `mem_ack` adds 1 stall cycle.
- `mem_*` outputs stay stable for the whole of WAIT.
- Memory must not ack when `mem_req`=0; an ack in IDLE or DONE is ignored.
- Reset asserted mid-WAIT: `mem_req` drops immediately (asynchronously); the in-flight access is abandoned.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC` without ack: drop `mem_req`, go to DONE with `cpu_rdata` = 0xDEADBEEF and `cpu_buserr`=1 for that cycle.
  - If `mem_ack` and the timeout coincide, ack wins.
- `DMEM_TIMEOUT_EN` undefined: no counter, WAIT persists until ack, and `cpu_buserr` is tied to 0.

## Structure
- Shared package `dmem_pkg`:
  - funct3 size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - FSM state enum.
  - `DMEM_BUSERR_DATA` = 32'hDEADBEEF.
- Sub-module `dmem_align` (purely combinational):
  - Inputs: size, offset, wdata, rdata.
  - Outputs: be, replicated wdata, extended rdata, misalign.
  - Instantiated once; the FSM lives in `dmem_ctrl`.

## Test plan
- Zero-wait memory, `lw` @0x100 with rdata 0x89ABCDEF: `mem_addr`=0x100, `be`=1111, stall for 2 cycles, `cpu_rdata`=0x89ABCDEF in DONE.
- `lb` @0x103 with rdata 0x80FF_FF7F: `cpu_rdata`=0xFFFFFF80. `lbu` at the same address gives 0x00000080. `lhu` @0x102 gives 0x000080FF.
- `sb` @0x101 with `wdata`=0x12345678: `mem_wdata`=0x78787878, `be`=0010. `sh` @0x102: `mem_wdata`=0x56785678, `be`=1100.
- `lw` @0x102, then `sh` @0x101: `cpu_misalign`=1, `cpu_stall`=0, `mem_req` never asserted.
- `mem_ack` delayed 5 cycles, with reset pulsed low in the 3rd WAIT cycle: `mem_req`=0 immediately, FSM in IDLE, all outputs at reset values.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYC`=4, no ack: DONE after 4 WAIT cycles with `cpu_rdata`=0xDEADBEEF and `cpu_buserr`=1. Ack arriving on the 4th cycle: normal data, `cpu_buserr`=0.
